sti_dac_gen: RTL and testbench
==============================

// Module: sti_dac_gen
// PURPOSE
//  Parametrised serial-transmitter / DAC-memory loader; successor to the fixed 16-bit STI+DAC block.
//  Accepts one parallel word per frame, pads/crops it to a programmable frame length and serialises it on so_data.
//  Packs the serial stream into bytes and writes them into NBANK odd/even bank pairs (checkerboard or linear order).
//  Adds a load handshake (pi_ready) and zero-fills unused memory once pi_end is seen.
// PARAMETERS
//  DW       16  parallel input data width (multiple of 8)
//  LEN_W    2   length-code width; frame length F = 8*(pi_length+1) bits, max 8*2^LEN_W
//  NBANK    4   number of odd/even bank pairs
//  AW       5   address width per bank; bytes per pair P = 2^(AW+1)
//  CB_MODE  1   1 = checkerboard odd/even order, 0 = plain alternation
//  CB_ROW   8   bytes per checkerboard row (power of 2, <= P)
// PORTS
//  clk          in   1      clock; all state on rising edge
//  reset        in   1      asynchronous, active-low reset
//  load         in   1      frame request; accepted only when pi_ready=1
//  pi_ready     out  1      block idle, can accept load
//  pi_data      in   DW     parallel data, sampled on accepted load
//  pi_length    in   LEN_W  frame length code
//  pi_fill      in   1      pad position when F>DW (see BEHAVIOUR)
//  pi_msb       in   1      1 = MSB-first serialisation, 0 = LSB-first
//  pi_low       in   1      when F<DW: 1 = upper F bits, 0 = lower F bits of pi_data
//  pi_end       in   1      sampled with load: this is the last frame
//  so_data      out  1      serial data
//  so_valid     out  1      so_data valid
//  oem_dataout  out  8      byte to memory
//  oem_addr     out  AW     memory address
//  odd_wr       out  NBANK  one-hot odd-bank write strobes
//  even_wr      out  NBANK  one-hot even-bank write strobes
//  oem_finish   out  1      all NBANK*P locations written
// BEHAVIOUR
//  Reset: pi_ready=1; so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish = 0; byte index k=0.
//  Reset mid-frame aborts immediately; no partial byte is written.
//  Frame value V (F bits): F<DW -> cropped per pi_low; F=DW -> pi_data; F>DW -> pi_fill=0: {zeros,pi_data}, pi_fill=1: {pi_data,zeros}.
//  FSM IDLE -> SEND (accepted load, cycle 0) -> GAP -> IDLE; GAP -> FILL if pi_end latched; FILL -> DONE.
//  SEND: so_valid=1 in cycles 1..F, one bit per cycle, order per pi_msb; pi_ready=0 cycles 1..F.
//  GAP (cycle F+1): so_valid=0, pi_ready=1; a load in F+1 is accepted, first bit in F+2.
//  load while pi_ready=0 is ignored; inputs need only be stable in the accept cycle.
//  Bytes: every 8 transmitted bits form one byte, first-sent bit = byte bit 7.
//  Byte j of a frame (1-based) completes in cycle 8j; its write strobe is a 1-cycle pulse in 8j+1 with oem_dataout/oem_addr valid that cycle.
//  Mapping of global byte index k: bank=k/P, p=k%P, oem_addr=p>>1;
//   CB_MODE=1: even if p[0]^(p/CB_ROW)[0], else odd; CB_MODE=0: even if p[0].
//  At most one of odd_wr|even_wr high per cycle.
//  k = NBANK*P reached: oem_finish=1 (sticky until reset); later frames still serialise, no memory writes.
//  FILL: from cycle F+2 one 0x00 write per cycle at successive k until full; so_valid=0; pi_ready=0.
//  DONE: oem_finish=1, pi_ready=0, all loads ignored until reset.
//  pi_end on a frame that fills memory exactly: skip FILL, go to DONE.
// TESTING
//  1 reset, load pi_data=16'hA5C3 len=0 msb=1 low=1 -> so 1010_0101 cycles 1-8; odd_wr[0], addr 0, data 8'hA5 in cycle 9.
//  2 load 16'h0001 len=1 msb=0 -> so 1 then fifteen 0s; bytes 8'h80 (odd0 addr0), 8'h00 (even0 addr0).
//  3 load 16'h1234 len=3 fill=1 msb=1 -> bytes 12,34,00,00; fill=0 -> bytes 00,00,12,34.
//  4 16 bytes, CB_MODE=1 -> bytes 0-7 odd,even,... addr 0-3; bytes 8-15 even,odd,... addr 4-7.
//  5 pi_end on frame 2 (len=0) -> 254 zero writes in consecutive cycles; oem_finish=1 after write 255 (k=255); odd_wr[3]/even_wr[3] last; later load ignored.
//  6 reset low mid-frame (bit 5) -> all outputs 0 next cycle; new frame restarts at k=0, odd_wr[0] addr 0.

Source files
------------

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: frame serialiser with byte packer and odd/even bank memory loader.
// Each accepted frame is cropped or padded to 8*(pi_length+1) bits and shifted
// out on so_data. Every 8 transmitted bits become one byte write, steered over
// NBANK odd/even bank pairs. After a frame flagged with pi_end, the remaining
// locations are zero-filled and the block parks in DONE until reset.
module sti_dac_gen #(
    parameter int DW      = 16,
    parameter int LEN_W   = 2,
    parameter int NBANK   = 4,
    parameter int AW      = 5,
    parameter int CB_MODE = 1,
    parameter int CB_ROW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    output logic             pi_ready,
    input  logic [DW-1:0]    pi_data,
    input  logic [LEN_W-1:0] pi_length,
    input  logic             pi_fill,
    input  logic             pi_msb,
    input  logic             pi_low,
    input  logic             pi_end,
    output logic             so_data,
    output logic             so_valid,
    output logic [7:0]       oem_dataout,
    output logic [AW-1:0]    oem_addr,
    output logic [NBANK-1:0] odd_wr,
    output logic [NBANK-1:0] even_wr,
    output logic             oem_finish
);

    localparam int FMAX   = 8 * (2 ** LEN_W);          // longest frame in bits
    localparam int VW     = (FMAX > DW) ? FMAX : DW;   // working width for crop/pad
    localparam int FW     = LEN_W + 4;                 // holds 0..FMAX
    localparam int P      = 2 ** (AW + 1);             // bytes per odd/even pair
    localparam int TOTAL  = NBANK * P;                 // bytes in the whole memory
    localparam int KW     = $clog2(TOTAL) + 1;         // holds 0..TOTAL
    localparam int ROW_SH = $clog2(CB_ROW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_FILL,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [FMAX-1:0]  sh_q, sh_d;          // remaining bits, next bit at MSB
    logic [FW-1:0]    f_q, f_d;            // frame length of the current frame
    logic [FW-1:0]    cnt_q, cnt_d;        // bits presented so far
    logic             end_q, end_d;        // current frame was flagged last
    logic             so_data_q, so_data_d;
    logic             so_valid_q, so_valid_d;
    logic [6:0]       byte_q, byte_d;      // first seven bits of the byte being packed
    logic [KW-1:0]    k_q, k_d;            // global byte index
    logic [7:0]       dout_q, dout_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [NBANK-1:0] odd_q, odd_d;
    logic [NBANK-1:0] even_q, even_d;
    logic             finish_q, finish_d;

    logic [FW-1:0]    f_new;
    logic [VW-1:0]    data_ext, mask, v_ext;
    logic [FMAX-1:0]  v_new, v_rev, sh_load;

    logic [KW-1:0]    p_k, bank_k;
    logic             cb_flip, wr_even;
    logic [AW-1:0]    wr_addr;
    logic [NBANK-1:0] wr_bank;

    logic             accept, mem_full, do_write;
    logic [7:0]       wr_data;

    // Crop or pad pi_data to the requested length and left-align it in send order.
    always_comb begin
        f_new    = (FW'(pi_length) + FW'(1)) << 3;
        data_ext = VW'(pi_data);
        mask     = {VW{1'b1}} >> (VW - int'(f_new));
        if (int'(f_new) < DW) begin
            v_ext = pi_low ? (data_ext >> (DW - int'(f_new))) : (data_ext & mask);
        end else if (int'(f_new) == DW) begin
            v_ext = data_ext;
        end else begin
            v_ext = pi_fill ? (data_ext << (int'(f_new) - DW)) : data_ext;
        end
        v_new = FMAX'(v_ext);
        for (int i = 0; i < FMAX; i++) begin
            v_rev[i] = v_new[FMAX-1-i];
        end
        sh_load = pi_msb ? (v_new << (FMAX - int'(f_new))) : v_rev;
    end

    // Map the global byte index onto bank, address and odd/even side.
    always_comb begin
        p_k     = k_q & KW'(P - 1);
        bank_k  = k_q >> (AW + 1);
        cb_flip = (CB_MODE != 0) && (((p_k >> ROW_SH) & KW'(1)) != '0);
        wr_even = p_k[0] ^ cb_flip;
        wr_addr = AW'(p_k >> 1);
        wr_bank = NBANK'(1) << bank_k;
    end

    assign mem_full = (k_q == KW'(TOTAL));
    assign pi_ready = (state_q == S_IDLE) || ((state_q == S_GAP) && !end_q);
    assign accept   = load && pi_ready;

    // Next state, serial output, byte packing and write-strobe generation.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d    = state_q;
        sh_d       = sh_q;
        f_d        = f_q;
        cnt_d      = cnt_q;
        end_d      = end_q;
        so_data_d  = 1'b0;
        so_valid_d = 1'b0;
        byte_d     = byte_q;
        k_d        = k_q;
        dout_d     = dout_q;
        addr_d     = addr_q;
        odd_d      = '0;
        even_d     = '0;
        finish_d   = finish_q | mem_full;
        do_write   = 1'b0;
        wr_data    = 8'h00;

        // Pack what is on so_data this cycle; the eighth bit completes a byte.
        if (so_valid_q) begin
            byte_d = {byte_q[5:0], so_data_q};
            if (cnt_q[2:0] == 3'd0) begin
                do_write = 1'b1;
                wr_data  = {byte_q, so_data_q};
            end
        end

        unique case (state_q)
            S_IDLE: ;
            S_SEND: begin
                if (cnt_q == f_q) begin
                    state_d = S_GAP;
                end else begin
                    so_valid_d = 1'b1;
                    so_data_d  = sh_q[FMAX-1];
                    sh_d       = sh_q << 1;
                    cnt_d      = cnt_q + FW'(1);
                end
            end
            S_GAP: begin
                if (end_q) begin
                    if (mem_full) begin
                        state_d = S_DONE;
                    end else begin
                        do_write = 1'b1;
                        state_d  = (k_q == KW'(TOTAL - 1)) ? S_DONE : S_FILL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                do_write = 1'b1;
                if (k_q == KW'(TOTAL - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        // A load accepted in IDLE or GAP starts the next frame; its first bit shows next cycle.
        if (accept) begin
            state_d    = S_SEND;
            f_d        = f_new;
            end_d      = pi_end;
            so_valid_d = 1'b1;
            so_data_d  = sh_load[FMAX-1];
            sh_d       = sh_load << 1;
            cnt_d      = FW'(1);
        end

        // Once every location is written, bytes are still serialised but not stored.
        if (do_write && !mem_full) begin
            dout_d = wr_data;
            addr_d = wr_addr;
            if (wr_even) begin
                even_d = wr_bank;
            end else begin
                odd_d = wr_bank;
            end
            k_d = k_q + KW'(1);
        end
    end

    // State and output registers; reset aborts any frame without writing a partial byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sh_q       <= '0;
            f_q        <= '0;
            cnt_q      <= '0;
            end_q      <= 1'b0;
            so_data_q  <= 1'b0;
            so_valid_q <= 1'b0;
            byte_q     <= '0;
            k_q        <= '0;
            dout_q     <= '0;
            addr_q     <= '0;
            odd_q      <= '0;
            even_q     <= '0;
            finish_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            sh_q       <= sh_d;
            f_q        <= f_d;
            cnt_q      <= cnt_d;
            end_q      <= end_d;
            so_data_q  <= so_data_d;
            so_valid_q <= so_valid_d;
            byte_q     <= byte_d;
            k_q        <= k_d;
            dout_q     <= dout_d;
            addr_q     <= addr_d;
            odd_q      <= odd_d;
            even_q     <= even_d;
            finish_q   <= finish_d;
        end
    end

    assign so_data     = so_data_q;
    assign so_valid    = so_valid_q;
    assign oem_dataout = dout_q;
    assign oem_addr    = addr_q;
    assign odd_wr      = odd_q;
    assign even_wr     = even_q;
    assign oem_finish  = finish_q;

endmodule

// File: tb/tb_sti_dac_gen.sv
// Scoreboard bench for sti_dac_gen: stimulus pushes expected serial bits and
// memory writes (with the cycle they must appear in); a monitor on the falling
// edge pops and compares whenever the DUT presents so_valid or a write strobe.
module tb_sti_dac_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        pi_ready;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        so_data;
    logic        so_valid;
    logic [7:0]  oem_dataout;
    logic [4:0]  oem_addr;
    logic [3:0]  odd_wr;
    logic [3:0]  even_wr;
    logic        oem_finish;

    typedef struct {
        int   cyc;
        logic b;
    } bit_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [4:0] addr;
        logic [3:0] odd;
        logic [3:0] even;
    } wr_t;

    bit_t exp_bits[$];
    wr_t  exp_wr[$];
    bit_t eb;
    wr_t  ew;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   exp_k  = 0;

    sti_dac_gen #(
        .DW(16), .LEN_W(2), .NBANK(4), .AW(5), .CB_MODE(1), .CB_ROW(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pi_ready   (pi_ready),
        .pi_data    (pi_data),
        .pi_length  (pi_length),
        .pi_fill    (pi_fill),
        .pi_msb     (pi_msb),
        .pi_low     (pi_low),
        .pi_end     (pi_end),
        .so_data    (so_data),
        .so_valid   (so_valid),
        .oem_dataout(oem_dataout),
        .oem_addr   (oem_addr),
        .odd_wr     (odd_wr),
        .even_wr    (even_wr),
        .oem_finish (oem_finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected write for the next global byte index, using the bank/odd/even mapping.
    task automatic push_write(input int c, input logic [7:0] d);
        wr_t w;
        int  p;
        int  bank;
        if (exp_k < 256) begin
            bank   = exp_k / 64;
            p      = exp_k % 64;
            w.cyc  = c;
            w.data = d;
            w.addr = 5'(p / 2);
            w.odd  = '0;
            w.even = '0;
            if ((((p % 2) ^ ((p / 8) % 2))) != 0) w.even = 4'(1 << bank);
            else                                  w.odd  = 4'(1 << bank);
            exp_wr.push_back(w);
            exp_k++;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (pi_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("ready_timeout", 64'(pi_ready), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_bits.size() != 0 || exp_wr.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("bits_left", 64'(exp_bits.size()), 64'd0);
        check("writes_left", 64'(exp_wr.size()), 64'd0);
    endtask

    // Issue one frame; stream holds the hand-computed bits, first-sent at bit 31.
    // keep > 0 limits expectations to the first keep bits (frame aborted by reset).
    task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fl,
                        input logic ms, input logic lo, input logic en,
                        input logic [31:0] stream, input int keep, output int a);
        int f;
        int nb;
        f  = 8 * (int'(len) + 1);
        nb = (keep == 0) ? f : keep;
        wait_ready();
        pi_data = d; pi_length = len; pi_fill = fl; pi_msb = ms; pi_low = lo; pi_end = en;
        load = 1'b1;
        a = cyc;
        for (int i = 0; i < nb; i++) exp_bits.push_back('{a + i + 1, stream[31 - i]});
        for (int j = 1; 8 * j <= nb; j++) push_write(a + 8 * j + 1, stream[39 - 8 * j -: 8]);
        @(posedge clk);
        #1;
        load = 1'b0;
        pi_data = ~d; pi_length = ~len; pi_fill = ~fl; pi_msb = ~ms; pi_low = ~lo; pi_end = 1'b0;
    endtask

    // Monitor: compare every serial bit and every write strobe against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (so_valid === 1'b1) begin
                check("busy_pi_ready", 64'(pi_ready), 64'd0);
                if (exp_bits.size() == 0) begin
                    check("so_unexpected", 64'(so_valid), 64'd0);
                end else begin
                    eb = exp_bits.pop_front();
                    check("so_cycle", 64'(cyc), 64'(eb.cyc));
                    check("so_data", 64'(so_data), 64'(eb.b));
                end
            end
            if ((odd_wr | even_wr) !== 4'd0) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", {56'd0, odd_wr, even_wr}, 64'd0);
                end else begin
                    ew = exp_wr.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(ew.cyc));
                    check("wr_word", {43'd0, oem_dataout, oem_addr, odd_wr, even_wr},
                          {43'd0, ew.data, ew.addr, ew.odd, ew.even});
                end
            end
        end
    end

    initial begin
        int a;
        reset = 1'b0; load = 1'b0; pi_data = '0; pi_length = '0;
        pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_pi_ready", 64'(pi_ready), 64'd1);
        check("rst_so", {62'd0, so_data, so_valid}, 64'd0);
        check("rst_mem", {43'd0, oem_dataout, oem_addr, odd_wr, even_wr}, 64'd0);
        check("rst_finish", 64'(oem_finish), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // A5C3, 8-bit frame, upper byte, MSB first -> A5 to odd0 addr0.
        send(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA500_0000, 0, a);
        drain();

        // Abort after the fifth bit: outputs clear, no partial byte written.
        send(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA500_0000, 5, a);
        repeat (5) @(negedge clk);
        #1 reset = 1'b0;
        exp_k = 0;
        @(negedge clk);
        check("abort_so", {62'd0, so_data, so_valid}, 64'd0);
        check("abort_mem", {43'd0, oem_dataout, oem_addr, odd_wr, even_wr}, 64'd0);
        check("abort_pi_ready", 64'(pi_ready), 64'd1);
        check("abort_bits_left", 64'(exp_bits.size()), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back frames, each new load landing in the previous frame's gap cycle.
        send(16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 0, a);
        send(16'h1234, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_0000, 0, a);
        // Loads while busy must be ignored.
        pi_data = 16'hFFFF; pi_end = 1'b1; load = 1'b1;
        repeat (4) @(negedge clk);
        load = 1'b0; pi_end = 1'b0;
        send(16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 0, a);
        send(16'h0012, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4800_0000, 0, a);
        send(16'hBEEF, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBEEF_0000, 0, a);
        send(16'h8001, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8001_0000, 0, a);
        send(16'h0003, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_C000, 0, a);
        send(16'hCAFE, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 0, a);
        send(16'hF00F, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hF000_0000, 0, a);
        drain();

        // Fresh memory: two 8-bit frames, the second with pi_end -> 254 zero writes.
        reset = 1'b0;
        exp_k = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA500_0000, 0, a);
        send(16'h3C00, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3C00_0000, 0, a);
        for (int i = 0; i < 254; i++) push_write(a + 10 + i, 8'h00);
        check("pre_finish", 64'(oem_finish), 64'd0);
        repeat (15) @(negedge clk);
        check("fill_pi_ready", 64'(pi_ready), 64'd0);
        check("fill_so_valid", 64'(so_valid), 64'd0);
        drain();
        @(negedge clk);
        check("done_finish", 64'(oem_finish), 64'd1);
        check("done_pi_ready", 64'(pi_ready), 64'd0);

        // Loads in DONE are ignored; the monitor flags any bit or write that appears.
        pi_data = 16'h5555; pi_length = 2'd0; pi_msb = 1'b1; load = 1'b1;
        repeat (20) @(negedge clk);
        load = 1'b0;
        check("done_so_valid", 64'(so_valid), 64'd0);
        check("done_finish_sticky", 64'(oem_finish), 64'd1);
        check("done_ready_after", 64'(pi_ready), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
